// File: rtl/axi_bus_arbiter.sv
// Two-requester AXI4 arbiter: ibus (s0) and dbus (s1) share one master port.
// Read and write directions are arbitrated by independent FSMs, one burst in flight each.
module axi_bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  // s0 read
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [7:0]          s0_arlen,
  input  logic [2:0]          s0_arsize,
  input  logic [1:0]          s0_arburst,
  input  logic                s0_arvalid,
  output logic                s0_arready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  output logic                s0_rlast,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  // s0 write
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [7:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  output logic [1:0]          s0_bresp,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  // s1 read
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [7:0]          s1_arlen,
  input  logic [2:0]          s1_arsize,
  input  logic [1:0]          s1_arburst,
  input  logic                s1_arvalid,
  output logic                s1_arready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  output logic                s1_rlast,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  // s1 write
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [7:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  output logic [1:0]          s1_bresp,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  // master read
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  // master write
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                proto_err,
  output logic [1:0]          dbg_rd_state,
  output logic [1:0]          dbg_wr_state
);

  // Handshakes: a beat transfers on the cycle valid && ready are both high; valid
  // never waits on ready. Only the granted requester sees the master's valid/ready.
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;

  rd_state_t  r_rstate;
  wr_state_t  r_wstate;
  logic       r_rgnt, r_wgnt;
  logic       r_rr_last_rd, r_rr_last_wr;
  logic [7:0] r_arlen, r_rbeat;
  logic [7:0] r_awlen, r_wbeat;
  logic       r_proto_err;

  logic w_rpick, w_wpick;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_rd_err, w_wr_err;
  logic w_in_raddr, w_in_rdata, w_in_waddr, w_in_wdata, w_in_wresp;

  // Both requesting: fixed priority favours dbus, otherwise alternate away from the last grant.
  function automatic logic pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return (FIXED_PRIO != 0) ? 1'b1 : ~last;
    return req1;
  endfunction

  assign w_rpick = pick(s0_arvalid, s1_arvalid, r_rr_last_rd);
  assign w_wpick = pick(s0_awvalid, s1_awvalid, r_rr_last_wr);

  assign w_in_raddr = (r_rstate == R_ADDR);
  assign w_in_rdata = (r_rstate == R_DATA);
  assign w_in_waddr = (r_wstate == W_ADDR);
  assign w_in_wdata = (r_wstate == W_DATA);
  assign w_in_wresp = (r_wstate == W_RESP);

  // Read address / data routing
  assign m_araddr   = r_rgnt ? s1_araddr  : s0_araddr;
  assign m_arlen    = r_rgnt ? s1_arlen   : s0_arlen;
  assign m_arsize   = r_rgnt ? s1_arsize  : s0_arsize;
  assign m_arburst  = r_rgnt ? s1_arburst : s0_arburst;
  assign m_arvalid  = w_in_raddr & (r_rgnt ? s1_arvalid : s0_arvalid);
  assign s0_arready = w_in_raddr & ~r_rgnt & m_arready;
  assign s1_arready = w_in_raddr &  r_rgnt & m_arready;
  assign s0_rdata   = m_rdata;
  assign s1_rdata   = m_rdata;
  assign s0_rresp   = m_rresp;
  assign s1_rresp   = m_rresp;
  assign s0_rlast   = m_rlast;
  assign s1_rlast   = m_rlast;
  assign s0_rvalid  = w_in_rdata & ~r_rgnt & m_rvalid;
  assign s1_rvalid  = w_in_rdata &  r_rgnt & m_rvalid;
  assign m_rready   = w_in_rdata & (r_rgnt ? s1_rready : s0_rready);

  // Write address / data / response routing
  assign m_awaddr   = r_wgnt ? s1_awaddr  : s0_awaddr;
  assign m_awlen    = r_wgnt ? s1_awlen   : s0_awlen;
  assign m_awsize   = r_wgnt ? s1_awsize  : s0_awsize;
  assign m_awburst  = r_wgnt ? s1_awburst : s0_awburst;
  assign m_awvalid  = w_in_waddr & (r_wgnt ? s1_awvalid : s0_awvalid);
  assign s0_awready = w_in_waddr & ~r_wgnt & m_awready;
  assign s1_awready = w_in_waddr &  r_wgnt & m_awready;
  assign m_wdata    = r_wgnt ? s1_wdata : s0_wdata;
  assign m_wstrb    = r_wgnt ? s1_wstrb : s0_wstrb;
  assign m_wlast    = r_wgnt ? s1_wlast : s0_wlast;
  assign m_wvalid   = w_in_wdata & (r_wgnt ? s1_wvalid : s0_wvalid);
  assign s0_wready  = w_in_wdata & ~r_wgnt & m_wready;
  assign s1_wready  = w_in_wdata &  r_wgnt & m_wready;
  assign s0_bresp   = m_bresp;
  assign s1_bresp   = m_bresp;
  assign s0_bvalid  = w_in_wresp & ~r_wgnt & m_bvalid;
  assign s1_bvalid  = w_in_wresp &  r_wgnt & m_bvalid;
  assign m_bready   = w_in_wresp & (r_wgnt ? s1_bready : s0_bready);

  assign w_ar_hs = m_arvalid & m_arready;
  assign w_r_hs  = w_in_rdata & m_rvalid & m_rready;
  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid & m_wready;
  assign w_b_hs  = w_in_wresp & m_bvalid & m_bready;

  // A last flag must appear exactly on the beat whose index equals the latched len.
  assign w_rd_err = w_r_hs & (m_rlast != (r_rbeat == r_arlen));
  assign w_wr_err = w_w_hs & (m_wlast != (r_wbeat == r_awlen));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rstate     <= R_IDLE;
      r_rgnt       <= 1'b0;
      r_rr_last_rd <= 1'b0;
      r_arlen      <= 8'd0;
      r_rbeat      <= 8'd0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s0_arvalid || s1_arvalid) begin
          r_rgnt       <= w_rpick;
          r_rr_last_rd <= w_rpick;
          r_rstate     <= R_ADDR;
        end
        R_ADDR: if (w_ar_hs) begin
          r_arlen  <= m_arlen;
          r_rbeat  <= 8'd0;
          r_rstate <= R_DATA;
        end
        R_DATA: if (w_r_hs) begin
          r_rbeat <= r_rbeat + 8'd1;
          if (m_rlast) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wstate     <= W_IDLE;
      r_wgnt       <= 1'b0;
      r_rr_last_wr <= 1'b0;
      r_awlen      <= 8'd0;
      r_wbeat      <= 8'd0;
    end else begin
      case (r_wstate)
        W_IDLE: if (s0_awvalid || s1_awvalid) begin
          r_wgnt       <= w_wpick;
          r_rr_last_wr <= w_wpick;
          r_wstate     <= W_ADDR;
        end
        W_ADDR: if (w_aw_hs) begin
          r_awlen  <= m_awlen;
          r_wbeat  <= 8'd0;
          r_wstate <= W_DATA;
        end
        W_DATA: if (w_w_hs) begin
          r_wbeat <= r_wbeat + 8'd1;
          if (m_wlast) r_wstate <= W_RESP;
        end
        W_RESP: if (w_b_hs) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_proto_err <= 1'b0;
    else if (w_rd_err || w_wr_err) r_proto_err <= 1'b1;
  end

  assign proto_err    = r_proto_err;
  assign dbg_rd_state = r_rstate;
  assign dbg_wr_state = r_wstate;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter: round-robin instance (full) plus a
// fixed-priority instance exercised on the read channel only.
module tb_axi_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- round-robin instance signals ----------------
  logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr;
  logic [7:0]  s0_arlen, s1_arlen, s0_awlen, s1_awlen;
  logic [2:0]  s0_arsize, s1_arsize, s0_awsize, s1_awsize;
  logic [1:0]  s0_arburst, s1_arburst, s0_awburst, s1_awburst;
  logic        s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid;
  logic        s0_arready, s1_arready, s0_awready, s1_awready;
  logic [31:0] s0_rdata, s1_rdata, s0_wdata, s1_wdata;
  logic [1:0]  s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready, proto_err;
  logic [1:0]  dbg_rd_state, dbg_wr_state;

  // ---------------- fixed-priority instance signals ----------------
  logic [31:0] b_s0_araddr, b_s1_araddr, b_s0_rdata, b_s1_rdata, b_m_araddr, b_m_rdata;
  logic [7:0]  b_s0_arlen, b_s1_arlen, b_m_arlen;
  logic        b_s0_arvalid, b_s1_arvalid, b_s0_arready, b_s1_arready;
  logic        b_s0_rvalid, b_s1_rvalid, b_s0_rlast, b_s1_rlast;
  logic [1:0]  b_s0_rresp, b_s1_rresp, b_m_rresp, b_m_arburst;
  logic [2:0]  b_m_arsize;
  logic        b_m_arvalid, b_m_arready, b_m_rlast, b_m_rvalid, b_m_rready;
  logic        b_s0_awready, b_s1_awready, b_s0_wready, b_s1_wready;
  logic [1:0]  b_s0_bresp, b_s1_bresp, b_m_awburst, b_dbg_rd, b_dbg_wr;
  logic        b_s0_bvalid, b_s1_bvalid, b_m_awvalid, b_m_wlast, b_m_wvalid, b_m_bready, b_proto_err;
  logic [31:0] b_m_awaddr, b_m_wdata;
  logic [7:0]  b_m_awlen;
  logic [2:0]  b_m_awsize;
  logic [3:0]  b_m_wstrb;

  axi_bus_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_bresp(s0_bresp),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_bresp(s1_bresp),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .proto_err(proto_err), .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  axi_bus_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .s0_araddr(b_s0_araddr), .s0_arlen(b_s0_arlen), .s0_arsize(3'd2), .s0_arburst(2'd1),
    .s0_arvalid(b_s0_arvalid), .s0_arready(b_s0_arready), .s0_rdata(b_s0_rdata), .s0_rresp(b_s0_rresp),
    .s0_rlast(b_s0_rlast), .s0_rvalid(b_s0_rvalid), .s0_rready(1'b1),
    .s0_awaddr(32'd0), .s0_awlen(8'd0), .s0_awsize(3'd0), .s0_awburst(2'd0),
    .s0_awvalid(1'b0), .s0_awready(b_s0_awready), .s0_wdata(32'd0), .s0_wstrb(4'd0),
    .s0_wlast(1'b0), .s0_wvalid(1'b0), .s0_wready(b_s0_wready), .s0_bresp(b_s0_bresp),
    .s0_bvalid(b_s0_bvalid), .s0_bready(1'b0),
    .s1_araddr(b_s1_araddr), .s1_arlen(b_s1_arlen), .s1_arsize(3'd2), .s1_arburst(2'd1),
    .s1_arvalid(b_s1_arvalid), .s1_arready(b_s1_arready), .s1_rdata(b_s1_rdata), .s1_rresp(b_s1_rresp),
    .s1_rlast(b_s1_rlast), .s1_rvalid(b_s1_rvalid), .s1_rready(1'b1),
    .s1_awaddr(32'd0), .s1_awlen(8'd0), .s1_awsize(3'd0), .s1_awburst(2'd0),
    .s1_awvalid(1'b0), .s1_awready(b_s1_awready), .s1_wdata(32'd0), .s1_wstrb(4'd0),
    .s1_wlast(1'b0), .s1_wvalid(1'b0), .s1_wready(b_s1_wready), .s1_bresp(b_s1_bresp),
    .s1_bvalid(b_s1_bvalid), .s1_bready(1'b0),
    .m_araddr(b_m_araddr), .m_arlen(b_m_arlen), .m_arsize(b_m_arsize), .m_arburst(b_m_arburst),
    .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .m_rdata(b_m_rdata), .m_rresp(b_m_rresp),
    .m_rlast(b_m_rlast), .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
    .m_awaddr(b_m_awaddr), .m_awlen(b_m_awlen), .m_awsize(b_m_awsize), .m_awburst(b_m_awburst),
    .m_awvalid(b_m_awvalid), .m_awready(1'b0), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
    .m_wlast(b_m_wlast), .m_wvalid(b_m_wvalid), .m_wready(1'b0), .m_bresp(2'd0),
    .m_bvalid(1'b0), .m_bready(b_m_bready),
    .proto_err(b_proto_err), .dbg_rd_state(b_dbg_rd), .dbg_wr_state(b_dbg_wr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serve one read burst for requester g, starting from the IDLE cycle in which
  // its arvalid is already visible. The granted requester drops arvalid after its handshake.
  task automatic serve_read(input int g, input logic [31:0] addr, input int nbeats, input int last_beat);
    logic [31:0] d;
    @(posedge clk); #1;
    check_eq("ar_valid", 64'(m_arvalid), 64'd1);
    check_eq("ar_addr", 64'(m_araddr), 64'(addr));
    m_arready = 1'b1; #1;
    check_eq("arready_gnt", 64'(g != 0 ? s1_arready : s0_arready), 64'd1);
    check_eq("arready_other", 64'(g != 0 ? s0_arready : s1_arready), 64'd0);
    @(posedge clk); #1;
    m_arready = 1'b0;
    if (g != 0) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      d = addr + 32'(i) * 32'h11;
      m_rdata = d; m_rvalid = 1'b1; m_rlast = (i == last_beat); #1;
      check_eq("rvalid_gnt", 64'(g != 0 ? s1_rvalid : s0_rvalid), 64'd1);
      check_eq("rvalid_other", 64'(g != 0 ? s0_rvalid : s1_rvalid), 64'd0);
      check_eq("rdata", 64'(g != 0 ? s1_rdata : s0_rdata), 64'(d));
      check_eq("m_rready", 64'(m_rready), 64'd1);
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; #1;
    check_eq("idle_gap", 64'(m_arvalid), 64'd0);
  endtask

  initial begin
    {s0_araddr, s1_araddr, s0_awaddr, s1_awaddr} = '0;
    {s0_arlen, s1_arlen, s0_awlen, s1_awlen} = '0;
    {s0_arsize, s1_arsize, s0_awsize, s1_awsize} = {4{3'd2}};
    {s0_arburst, s1_arburst, s0_awburst, s1_awburst} = {4{2'd1}};
    {s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid} = '0;
    {s0_wdata, s1_wdata, s0_wlast, s1_wlast, s0_wvalid, s1_wvalid} = '0;
    s0_wstrb = 4'hF; s1_wstrb = 4'hF;
    s0_rready = 1'b1; s1_rready = 1'b1; s0_bready = 1'b1; s1_bready = 1'b1;
    {m_arready, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
    {m_awready, m_wready, m_bresp, m_bvalid} = '0;
    {b_s0_araddr, b_s1_araddr, b_s0_arlen, b_s1_arlen, b_s0_arvalid, b_s1_arvalid} = '0;
    {b_m_arready, b_m_rdata, b_m_rresp, b_m_rlast, b_m_rvalid} = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_state", 64'(dbg_rd_state), 64'd0);
    check_eq("rst_wr_state", 64'(dbg_wr_state), 64'd0);
    check_eq("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check_eq("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    check_eq("rst_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single s0 read, len=3: one cycle of grant latency, four beats to s0 only
    s0_araddr = 32'h100; s0_arlen = 8'd3; s0_arvalid = 1'b1; #1;
    check_eq("grant_latency", 64'(m_arvalid), 64'd0);
    serve_read(0, 32'h100, 4, 3);
    check_eq("single_no_err", 64'(proto_err), 64'd0);

    // Round robin: both request with rr_last=0 -> s1, s0, then s1, s0 again
    for (int rep = 0; rep < 2; rep++) begin
      s0_araddr = 32'h100; s0_arlen = 8'd1; s0_arvalid = 1'b1;
      s1_araddr = 32'h200; s1_arlen = 8'd1; s1_arvalid = 1'b1;
      serve_read(1, 32'h200, 2, 1);
      serve_read(0, 32'h100, 2, 1);
    end
    check_eq("rr_no_err", 64'(proto_err), 64'd0);

    // s1 write len=1; W presented early must not be forwarded before AW handshake
    s1_awaddr = 32'h2000; s1_awlen = 8'd1; s1_awvalid = 1'b1;
    s1_wdata = 32'hDEADBEEF; s1_wlast = 1'b0; s1_wvalid = 1'b1; m_wready = 1'b1; #1;
    check_eq("aw_latency", 64'(m_awvalid), 64'd0);
    @(posedge clk); #1;
    check_eq("aw_valid", 64'(m_awvalid), 64'd1);
    check_eq("aw_addr", 64'(m_awaddr), 64'h2000);
    check_eq("w_before_aw", 64'(m_wvalid), 64'd0);
    m_awready = 1'b1; #1;
    check_eq("awready_s1", 64'(s1_awready), 64'd1);
    check_eq("awready_s0", 64'(s0_awready), 64'd0);
    check_eq("wready_before_aw", 64'(s1_wready), 64'd0);
    @(posedge clk); #1;
    s1_awvalid = 1'b0; m_awready = 1'b0; #1;
    check_eq("w0_valid", 64'(m_wvalid), 64'd1);
    check_eq("w0_data", 64'(m_wdata), 64'hDEADBEEF);
    check_eq("w0_last", 64'(m_wlast), 64'd0);
    check_eq("w0_wready", 64'(s1_wready), 64'd1);
    @(posedge clk); #1;
    s1_wdata = 32'h12345678; s1_wlast = 1'b1; #1;
    check_eq("w1_data", 64'(m_wdata), 64'h12345678);
    check_eq("w1_last", 64'(m_wlast), 64'd1);
    @(posedge clk); #1;
    s1_wvalid = 1'b0; s1_wlast = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'd0; #1;
    check_eq("w_done", 64'(m_wvalid), 64'd0);
    check_eq("b_valid_s1", 64'(s1_bvalid), 64'd1);
    check_eq("b_resp_s1", 64'(s1_bresp), 64'd0);
    check_eq("b_valid_s0", 64'(s0_bvalid), 64'd0);
    check_eq("m_bready", 64'(m_bready), 64'd1);
    @(posedge clk); #1;
    m_bvalid = 1'b0; #1;
    check_eq("wr_idle", 64'(dbg_wr_state), 64'd0);
    check_eq("wr_no_err", 64'(proto_err), 64'd0);

    // Early rlast on beat 2 of a len=3 read -> sticky proto_err
    s0_araddr = 32'h180; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    serve_read(0, 32'h180, 3, 2);
    check_eq("err_set", 64'(proto_err), 64'd1);
    s1_araddr = 32'h280; s1_arlen = 8'd0; s1_arvalid = 1'b1;
    serve_read(1, 32'h280, 1, 0);
    check_eq("err_sticky", 64'(proto_err), 64'd1);

    // Reset during beat 1 of a 4-beat read
    s0_araddr = 32'h300; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0; s0_arvalid = 1'b0;
    m_rdata = 32'h300; m_rvalid = 1'b1; m_rlast = 1'b0;
    @(posedge clk); #1;
    m_rdata = 32'h311; rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_rvalid", 64'(s0_rvalid), 64'd0);
    check_eq("mid_rst_rready", 64'(m_rready), 64'd0);
    check_eq("mid_rst_rd_state", 64'(dbg_rd_state), 64'd0);
    check_eq("mid_rst_err", 64'(proto_err), 64'd0);
    m_rvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    s0_araddr = 32'h400; s0_arlen = 8'd1; s0_arvalid = 1'b1;
    serve_read(0, 32'h400, 2, 1);
    check_eq("post_rst_no_err", 64'(proto_err), 64'd0);

    // Fixed priority: both request continuously, len=0 -> s1 wins every burst
    b_s0_araddr = 32'h100; b_s1_araddr = 32'h200;
    b_s0_arvalid = 1'b1; b_s1_arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("fp_ar_valid", 64'(b_m_arvalid), 64'd1);
      check_eq("fp_ar_addr", 64'(b_m_araddr), 64'h200);
      b_m_arready = 1'b1; #1;
      check_eq("fp_arready_s1", 64'(b_s1_arready), 64'd1);
      check_eq("fp_arready_s0", 64'(b_s0_arready), 64'd0);
      @(posedge clk); #1;
      b_m_arready = 1'b0; b_m_rvalid = 1'b1; b_m_rlast = 1'b1; #1;
      check_eq("fp_rvalid_s1", 64'(b_s1_rvalid), 64'd1);
      check_eq("fp_rvalid_s0", 64'(b_s0_rvalid), 64'd0);
      @(posedge clk); #1;
      b_m_rvalid = 1'b0; b_m_rlast = 1'b0; #1;
      check_eq("fp_idle_gap", 64'(b_m_arvalid), 64'd0);
    end
    b_s0_arvalid = 1'b0; b_s1_arvalid = 1'b0;
    check_eq("fp_no_err", 64'(b_proto_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
